// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: FSM states,
// forward-select encodings and the load-use counter preset helper.
package hazard_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } hzd_state_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  localparam int LU_CNT_W = 2;

  // The hit cycle is the first bubble, so the counter covers the rest minus one.
  function automatic logic [LU_CNT_W-1:0] lu_init(input int cycles);
    return (cycles > 1) ? LU_CNT_W'(cycles - 2) : '0;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forward-select for one EX-stage source operand; EX/MEM beats MEM/WB and
// register 0 is never forwarded.
module fwd_select
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             exmem_regwr,
  input  logic [REG_W-1:0] exmem_wsel,
  input  logic             memwb_regwr,
  input  logic [REG_W-1:0] memwb_wsel,
  output fwd_sel_t         sel
);

  always_comb begin
    sel = FWD_RF;
    if (exmem_regwr && (exmem_wsel != '0) && (exmem_wsel == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_regwr && (memwb_wsel != '0) && (memwb_wsel == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: load-use stalls,
// branch/jump flushes, halt drain and saturating stall/flush counters.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_W           = 5,
  parameter int NSRC            = 2,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int DRAIN_CYCLES    = 3,
  parameter int CNT_W           = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ihit,
  input  logic                  dhit,
  input  logic                  dmem_req,
  input  logic                  branch_flush,
  input  logic                  jump_flush,
  input  logic                  halt_ex,
  input  logic                  idex_memread,
  input  logic [REG_W-1:0]      idex_wsel,
  input  logic [REG_W-1:0]      id_rs,
  input  logic [REG_W-1:0]      id_rt,
  input  logic [NSRC*REG_W-1:0] ex_src,
  input  logic                  exmem_regwr,
  input  logic                  memwb_regwr,
  input  logic [REG_W-1:0]      exmem_wsel,
  input  logic [REG_W-1:0]      memwb_wsel,
  output logic                  pc_wen,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic                  exmem_en,
  output logic                  exmem_flush,
  output logic                  memwb_en,
  output logic [NSRC*2-1:0]     fwd_sel,
  output logic                  halt_done,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output hzd_state_t            state
);

  localparam int                   DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0]   DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [LU_CNT_W-1:0]  LU_INIT    = lu_init(LOAD_USE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_MAX    = '1;

  for (genvar i = 0; i < NSRC; i++) begin : g_fwd
    fwd_sel_t sel_e;
    fwd_select #(.REG_W(REG_W)) u_fwd (
      .src         (ex_src[i*REG_W +: REG_W]),
      .exmem_regwr (exmem_regwr),
      .exmem_wsel  (exmem_wsel),
      .memwb_regwr (memwb_regwr),
      .memwb_wsel  (memwb_wsel),
      .sel         (sel_e)
    );
    assign fwd_sel[i*2 +: 2] = sel_e;
  end

  logic [LU_CNT_W-1:0] lu_cnt, lu_cnt_n;
  logic [DRAIN_W-1:0]  drain_cnt, drain_cnt_n;
  hzd_state_t          state_n;
  logic frozen, active, lu_hit, flush_req;
  logic pc_wen_c, ifid_en_c, ifid_flush_c, idex_flush_c, back_en_c;
  logic count_flush, count_stall;

  assign frozen    = dmem_req & ~dhit;
  assign active    = ~RST & ~frozen;
  assign flush_req = branch_flush | jump_flush;
  assign lu_hit    = idex_memread & (idex_wsel != '0) &
                     ((idex_wsel == id_rs) | (idex_wsel == id_rt));

  always_comb begin
    pc_wen_c     = 1'b0;
    ifid_en_c    = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    back_en_c    = 1'b0;
    count_flush  = 1'b0;
    state_n      = state;
    lu_cnt_n     = lu_cnt;
    drain_cnt_n  = drain_cnt;
    if (active) begin
      case (state)
        RUN: begin
          back_en_c = 1'b1;
          if (flush_req) begin
            pc_wen_c     = 1'b1;
            ifid_flush_c = 1'b1;
            idex_flush_c = branch_flush;
            count_flush  = 1'b1;
          end else if (lu_hit) begin
            idex_flush_c = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              state_n  = LU_STALL;
              lu_cnt_n = LU_INIT;
            end
          end else if (!ihit) begin
            idex_flush_c = 1'b1;
          end else begin
            pc_wen_c  = 1'b1;
            ifid_en_c = 1'b1;
          end
          // Halt wins the next-state decision even over a fresh load-use stall.
          if (halt_ex) begin
            state_n     = DRAIN;
            drain_cnt_n = DRAIN_INIT;
          end
        end
        LU_STALL: begin
          back_en_c = 1'b1;
          if (flush_req) begin
            pc_wen_c     = 1'b1;
            ifid_flush_c = 1'b1;
            idex_flush_c = branch_flush;
            count_flush  = 1'b1;
            state_n      = RUN;
          end else begin
            idex_flush_c = 1'b1;
            if (lu_cnt == '0) state_n = RUN;
            else              lu_cnt_n = lu_cnt - LU_CNT_W'(1);
          end
        end
        DRAIN: begin
          back_en_c    = 1'b1;
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          if (drain_cnt == '0) state_n = HALTED;
          else                 drain_cnt_n = drain_cnt - DRAIN_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign count_stall = ((state == RUN) || (state == LU_STALL)) & ~pc_wen_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      lu_cnt    <= '0;
      drain_cnt <= '0;
      halt_done <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      lu_cnt    <= lu_cnt_n;
      drain_cnt <= drain_cnt_n;
      if (state_n == HALTED) halt_done <= 1'b1;
      if (count_stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (count_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign pc_wen      = pc_wen_c;
  assign ifid_en     = ifid_en_c;
  assign ifid_flush  = ifid_flush_c;
  assign idex_en     = back_en_c;
  assign idex_flush  = idex_flush_c;
  assign exmem_en    = back_en_c;
  assign exmem_flush = 1'b0;
  assign memwb_en    = back_en_c;

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Next-generation hazard and forwarding controller for the 5-stage MIPS pipeline.
- Generalises the fixed two-operand hazard unit to NSRC forwarded operands.
- Adds a multi-cycle load-use stall counter, a halt-drain FSM with a sticky halt_done, and saturating stall/flush performance counters.
- Sits beside the datapath and drives the PC write enable plus all pipeline-latch enables and flushes.

Parameters:
REG_W, 5, register-index width
NSRC, 2, number of EX-stage source operands needing forward selects (1..4)
LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (1..4)
DRAIN_CYCLES, 3, cycles the back end runs after halt before halt_done
CNT_W, 32, performance counter width

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
ihit  in  1  instruction fetch complete
dhit  in  1  data access complete
dmem_req  in  1  MEM stage holds a load/store
branch_flush  in  1  taken branch resolved; flush IF/ID and ID/EX
jump_flush  in  1  jump taken; flush IF/ID
halt_ex  in  1  halt instruction in EX
idex_memread  in  1  EX instruction is a load
idex_wsel  in  REG_W  EX destination register
id_rs, id_rt  in  REG_W each  ID source registers
ex_src  in  NSRC*REG_W  EX source registers, operand i at [i*REG_W +: REG_W]
exmem_regwr, memwb_regwr  in  1 each  stage writes the register file
exmem_wsel, memwb_wsel  in  REG_W each  stage destination
pc_wen  out  1  PC write enable
ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en  out  1 each  latch controls
fwd_sel  out  NSRC*2  per-operand select: 0 register file, 1 EX/MEM, 2 MEM/WB
halt_done  out  1  pipeline drained, sticky
stall_cnt  out  CNT_W  cycles with pc_wen=0 in RUN/LU_STALL
flush_cnt  out  CNT_W  accepted flush cycles

Behaviour:
- Reset (async, RST=1):
  - state=RUN; lu_cnt=0; drain_cnt=0; halt_done=0; counters=0.
  - All enables, flushes and pc_wen forced to 0 while RST is high.
  - fwd_sel stays combinational.
- Forwarding (combinational, per operand i):
  - EX/MEM match (exmem_regwr, exmem_wsel!=0, equal to operand) -> 1.
  - Otherwise MEM/WB match under the same rule -> 2.
  - Otherwise 0. EX/MEM has priority. Register 0 is never forwarded.
- frozen = dmem_req & ~dhit:
  - All enables 0, all flushes 0, pc_wen 0.
  - FSM counters hold.
  - Overrides every other condition.
- Not frozen:
  - exmem_en=1, memwb_en=1, idex_en=1, exmem_flush=0.
- lu_hit = idex_memread & idex_wsel!=0 & (idex_wsel==id_rs | idex_wsel==id_rt).
- RUN state:
  - Flush case (branch_flush | jump_flush):
    - pc_wen=1, ifid_flush=1.
    - idex_flush=branch_flush.
    - Flush beats lu_hit; flush_cnt+1.
  - lu_hit case:
    - pc_wen=0, ifid_en=0, idex_flush=1.
    - If LOAD_USE_CYCLES>1: go to LU_STALL with lu_cnt=LOAD_USE_CYCLES-2.
  - ~ihit case:
    - pc_wen=0, ifid_en=0, idex_flush=1.
  - Otherwise:
    - pc_wen=1, ifid_en=1.
  - halt_ex (checked after the rules above): go to DRAIN with drain_cnt=DRAIN_CYCLES-1.
- LU_STALL state:
  - Same outputs as the lu_hit case.
  - Flush input: apply flush outputs and return to RUN immediately.
  - lu_cnt==0 -> RUN; else lu_cnt-1.
- DRAIN state:
  - pc_wen=0, ifid_flush=1, idex_flush=1.
  - Back end advances.
  - drain_cnt==0 -> HALTED; else drain_cnt-1.
- HALTED state:
  - All enables 0, pc_wen 0, halt_done=1.
  - Leaves only on RST.
- stall_cnt:
  - +1 on each unfrozen or frozen cycle with pc_wen=0 in RUN/LU_STALL.
  - Saturates at all-ones.
- flush_cnt:
  - Saturates at all-ones.
  - Does not count while frozen.
- Reset mid-stall or mid-drain: everything returns to RUN values asynchronously.

Decomposition:
- Shared package (cpu_types_pkg addition):
  - hzd_state_t enum {RUN, LU_STALL, DRAIN, HALTED}.
  - fwd_sel_t enum {FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2}.
- Sub-module fwd_select: combinational, one operand; instantiated NSRC times by a generate loop.
- FSM, counters and enable logic stay in hazard_ctrl_unit.

Test Plan:
- Forwarding: exmem_regwr=1, exmem_wsel=8, memwb_regwr=1, memwb_wsel=8, ex_src op0=8, op1=0 -> fwd_sel op0=1, op1=0. Then drop exmem_regwr -> op0=2.
- Load-use: LOAD_USE_CYCLES=3, idex_memread=1, idex_wsel=4, id_rt=4, ihit=1 -> exactly 3 consecutive cycles of pc_wen=0, ifid_en=0, idex_flush=1; stall_cnt=3.
- Freeze priority: dmem_req=1, dhit=0 for 4 cycles during LU_STALL -> all enables 0 and lu_cnt held. Stall resumes and ends after the remaining bubbles once dhit=1.
- Flush: branch_flush with coincident lu_hit -> ifid_flush=1, idex_flush=1, pc_wen=1, no stall; flush_cnt=1. jump_flush alone -> idex_flush=0.
- Halt: DRAIN_CYCLES=3, halt_ex pulse -> 3 cycles of pc_wen=0 with both flushes set, then halt_done=1 and enables 0. halt_done stays set until RST.
- Async reset: RST pulse mid-DRAIN, between clock edges -> outputs 0 immediately. After release: RUN, counters 0, halt_done 0.
